// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser and per-bit bounce filter. Each bit
// publishes a clean level and one-cycle rise/fall pulses.
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to re-pulse rise on bits
// held high (first after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks).

module input_debouncer_lane #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INIT_LEVEL      = 1'b0,
  parameter int   REPEAT_DELAY    = 8,
  parameter int   REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {STABLE, PENDING} fstate_e;

  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, acc_rise, acc_fall, rep_pulse;
  fstate_e       st;

  // two-flop synchroniser; only sync2 feeds the filter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= INIT_LEVEL;
      sync2 <= INIT_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // filter state is implied by whether the synced pin disagrees with level
  assign st = (sync2 == level) ? STABLE : PENDING;

  // count ticks while pending; accept on the tick that completes the window
  always_comb begin
    cnt_n    = cnt;
    level_n  = level;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    if (st == STABLE) begin
      cnt_n = '0;
    end else if (tick) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_n    = '0;
        level_n  = sync2;
        acc_rise = sync2;
        acc_fall = ~sync2;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt, rcnt_n, rlim;
  logic          rep, rep_n;

  // rep flags that the initial delay has elapsed and we are in the periodic phase
  assign rlim = rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

  // repeat timer runs only on a steady high level; any transition restarts it
  always_comb begin
    rcnt_n    = rcnt;
    rep_n     = rep;
    rep_pulse = 1'b0;
    if (!level || (level_n != level)) begin
      rcnt_n = '0;
      rep_n  = 1'b0;
    end else if (tick) begin
      if (rcnt == rlim) begin
        rcnt_n    = '0;
        rep_n     = 1'b1;
        rep_pulse = 1'b1;
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
    end
  end

  // repeat timer registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else begin
      rcnt <= rcnt_n;
      rep  <= rep_n;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  // filter state and registered pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= acc_rise | rep_pulse;
      fall  <= acc_fall;
    end
  end
endmodule

module input_debouncer #(
  parameter int   N_IN            = 8,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   TICK_DIV        = 1,
  parameter logic INIT_LEVEL      = 1'b0,
  parameter int   REPEAT_DELAY    = 8,
  parameter int   REPEAT_PERIOD   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_IN-1:0] raw_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic            tick_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // filters see the combinational tick; tick_o is its registered copy
  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  // prescaler wraps on the tick cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      tick_o  <= tick;
    end
  end

  input_debouncer_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INIT_LEVEL      (INIT_LEVEL),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_lane [N_IN-1:0] (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick),
    .raw    (raw_i),
    .level  (level_o),
    .rise   (rise_o),
    .fall   (fall_o)
  );
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed stimulus on two instances (TICK_DIV=1 and 3),
// an arithmetic reference model checked every cycle, plus literal expectations.
module tb_input_debouncer;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] raw_a = 8'hFF, raw_b = 8'h00;
  logic [7:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_debouncer #(.N_IN(8), .DEBOUNCE_CYCLES(DC), .TICK_DIV(1), .INIT_LEVEL(1'b0),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .resetn(resetn), .raw_i(raw_a),
    .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .tick_o(tick_a));

  input_debouncer #(.N_IN(8), .DEBOUNCE_CYCLES(DC), .TICK_DIV(3), .INIT_LEVEL(1'b0),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .resetn(resetn), .raw_i(raw_b),
    .level_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .tick_o(tick_b));

  // ---------------- reference model ----------------
  // Edge k counts from the first edge after reset release. Tick edges are
  // those with k % td == td-1. A mismatch run starting at edge k0 is accepted
  // once the number of tick edges in [k0,k] reaches DC.
  logic [7:0] m_lvl[2], m_rise[2], m_fall[2], m_s1[2], m_s2[2];
  logic       m_tick[2];
  int         m_k[2];
  int         m_run[2][8];
  int         m_acc[2][8];
  int         rc_a[8] = '{default: 0};
  int         rc_b[8] = '{default: 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mstep(input int u, input logic [7:0] r, input logic rn);
    int   td, n, k;
    logic s, tk, was;
    td = (u == 0) ? 1 : 3;
    if (!rn) begin
      m_lvl[u] = '0; m_s1[u] = '0; m_s2[u] = '0;
      m_rise[u] = '0; m_fall[u] = '0; m_tick[u] = 1'b0; m_k[u] = 0;
      for (int i = 0; i < 8; i++) begin
        m_run[u][i] = -1;
        m_acc[u][i] = -1;
      end
    end else begin
      k  = m_k[u];
      tk = ((k % td) == td - 1);
      m_rise[u] = '0;
      m_fall[u] = '0;
      for (int i = 0; i < 8; i++) begin
        s   = m_s2[u][i];
        was = m_lvl[u][i];
        if (s == was) begin
          m_run[u][i] = -1;
        end else begin
          if (m_run[u][i] < 0) m_run[u][i] = k;
          n = (k + 1) / td - m_run[u][i] / td;
          if (n >= DC) begin
            m_lvl[u][i] = s;
            m_run[u][i] = -1;
            if (s) begin
              m_rise[u][i] = 1'b1;
              m_acc[u][i]  = k;
            end else begin
              m_fall[u][i] = 1'b1;
              m_acc[u][i]  = -1;
            end
          end
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (was && m_lvl[u][i] && m_acc[u][i] >= 0 && tk) begin
          n = (k + 1) / td - (m_acc[u][i] + 1) / td;
          if (n >= RD && ((n - RD) % RP) == 0) m_rise[u][i] = 1'b1;
        end
`endif
      end
      m_tick[u] = tk;
      m_s2[u]   = m_s1[u];
      m_s1[u]   = r;
      m_k[u]    = k + 1;
    end
  endtask

  // compare process: step model on the values seen at posedge, check at negedge
  initial begin
    logic [7:0] ra, rb;
    logic       rn;
    forever begin
      @(posedge clk);
      ra = raw_a; rb = raw_b; rn = resetn;
      mstep(0, ra, rn);
      mstep(1, rb, rn);
      @(negedge clk);
      chk("model_a", {7'b0, lvl_a, rise_a, fall_a, tick_a},
                     {7'b0, m_lvl[0], m_rise[0], m_fall[0], m_tick[0]});
      chk("model_b", {7'b0, lvl_b, rise_b, fall_b, tick_b},
                     {7'b0, m_lvl[1], m_rise[1], m_fall[1], m_tick[1]});
      for (int i = 0; i < 8; i++) begin
        if (rise_a[i] === 1'b1) rc_a[i]++;
        if (rise_b[i] === 1'b1) rc_b[i]++;
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base, n, w;
    resetn = 1'b0; raw_a = 8'hFF; raw_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(lvl_a), 32'h00);
    chk("rst_pulses", 32'(rise_a | fall_a), 32'h00);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_rel_pre", 32'(lvl_a), 32'h00);
    @(negedge clk);
    chk("rst_rel_level", 32'(lvl_a), 32'hFF);
    chk("rst_rel_rise", 32'(rise_a), 32'hFF);
    @(negedge clk);
    chk("rst_rel_rise_1cyc", 32'(rise_a), 32'h00);
    raw_a = 8'h00;
    repeat (10) @(negedge clk);
    chk("all_low", 32'(lvl_a), 32'h00);

    // glitch: 3 cycles high is one short
    base = rc_a[0];
    raw_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    raw_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_level", 32'(lvl_a[0]), 32'd0);
    chk("glitch_rise", rc_a[0] - base, 32'd0);

    // clean press/release on bit 3
    raw_a[3] = 1'b1;
    repeat (5) @(negedge clk);
    chk("press_early", 32'(rise_a[3]), 32'd0);
    @(negedge clk);
    chk("press_rise", 32'(rise_a[3]), 32'd1);
    @(negedge clk);
    chk("press_rise_1cyc", 32'(rise_a[3]), 32'd0);
    repeat (3) @(negedge clk);
    raw_a[3] = 1'b0;
    repeat (5) @(negedge clk);
    chk("release_early", 32'(fall_a[3]), 32'd0);
    @(negedge clk);
    chk("release_fall", 32'(fall_a[3]), 32'd1);
    @(negedge clk);
    chk("release_fall_1cyc", 32'(fall_a[3]), 32'd0);
    repeat (3) @(negedge clk);

    // bounce train on bit 5, then steady high
    base = rc_a[5];
    for (int j = 0; j < 6; j++) begin
      raw_a[5] = (j % 2 == 0);
      @(negedge clk);
    end
    raw_a[5] = 1'b1;
    repeat (5) @(negedge clk);
    chk("bounce_early", 32'(rise_a[5]), 32'd0);
    @(negedge clk);
    chk("bounce_rise", 32'(rise_a[5]), 32'd1);
    repeat (6) @(negedge clk);
    chk("bounce_one_pulse", rc_a[5] - base, 32'd1);

    // reset mid-count discards the pending change
    raw_a[6] = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0; raw_a = 8'h00;
    @(negedge clk);
    resetn = 1'b1;
    base = rc_a[6];
    repeat (12) @(negedge clk);
    chk("midrst_no_rise", rc_a[6] - base, 32'd0);
    chk("midrst_level", 32'(lvl_a), 32'h00);

    // prescaler instance: tick period and accept latency
    w = 0;
    while (tick_b !== 1'b1 && w < 6) begin
      @(negedge clk);
      w++;
    end
    chk("tick_found", 32'(tick_b), 32'd1);
    @(negedge clk); chk("tick_gap1", 32'(tick_b), 32'd0);
    @(negedge clk); chk("tick_gap2", 32'(tick_b), 32'd0);
    @(negedge clk); chk("tick_period3", 32'(tick_b), 32'd1);
    base = rc_b[1];
    raw_b[1] = 1'b1;
    n = 0;
    while (lvl_b[1] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("presc_latency_9_14", 32'((n - 1 >= 9) && (n - 1 <= 14)), 32'd1);
    repeat (20) @(negedge clk);
    chk("presc_one_pulse", rc_b[1] - base, 32'd1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // held bit 2: acceptance plus repeats at +8,+12,+16,+20,+24
    base = rc_a[2];
    raw_a[2] = 1'b1;
    repeat (30) @(negedge clk);
    chk("autorep_count", rc_a[2] - base, 32'd6);
    raw_a[2] = 1'b0;
    repeat (20) @(negedge clk);
    chk("autorep_released", 32'(lvl_a[2]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
